fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch front end for the CPU: owns the PC, issues sequential
//  requests to an instruction memory of arbitrary latency, buffers returned words in a
//  QDEPTH-entry queue and hands {pc, instr} to decode over a valid/ready handshake.
//  Supports redirect (branch/jump) with queue flush and discard of in-flight responses.
// PARAMETERS
//  XLEN      32      instruction/PC width in bits
//  QDEPTH    4       instruction queue entries (power of 2, >=2); also max outstanding requests
//  RESET_PC  32'h0   PC loaded at reset
// PORTS
//  clk_i          in   1     clock, rising edge
//  rst_i          in   1     asynchronous reset, active high
//  start_i        in   1     level; fetch enabled while high
//  imem_req_o     out  1     request valid
//  imem_addr_o    out  XLEN  request address (word aligned)
//  imem_gnt_i     in   1     request accepted when imem_req_o & imem_gnt_i
//  imem_rvalid_i  in   1     response valid; responses return in request order
//  imem_rdata_i   in   XLEN  response instruction word
//  instr_valid_o  out  1     queue head valid
//  instr_o        out  XLEN  queue head instruction
//  pc_o           out  XLEN  address of instr_o
//  instr_ready_i  in   1     decode accepts head when instr_valid_o & instr_ready_i
//  redirect_i     in   1     flush and restart fetch at redirect_pc_i
//  redirect_pc_i  in   XLEN  new PC; bits [1:0] ignored (forced to 0)
// BEHAVIOUR
//  Reset: state IDLE, fetch PC=RESET_PC, rsp PC=RESET_PC, queue empty, outstanding=0,
//   discard=0; imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, pc_o=0.
//  FSM: IDLE -> RUN when start_i=1; RUN -> IDLE when start_i=0. IDLE issues no requests
//   but accepts responses and keeps draining the queue to decode.
//  Issue (RUN): imem_req_o=1 iff count+outstanding < QDEPTH and not redirect_i this cycle;
//   imem_addr_o=fetch PC; on grant fetch PC += 4 (mod 2^XLEN, 0xFFFFFFFC wraps to 0),
//   outstanding++. Request held stable until granted unless redirect_i.
//  Response: if discard>0, word dropped, discard--, outstanding--; else written to queue
//   with pc = rsp PC, rsp PC += 4. Credit rule guarantees queue never overflows.
//  Decode: head presented combinationally from queue registers; pop on valid&ready.
//   Min latency grant->instr_valid_o = memory latency + 1 cycle.
//  Redirect (highest priority): queue emptied next cycle; discard <= outstanding minus any
//   response arriving this cycle (that response also dropped); fetch PC and rsp PC <=
//   {redirect_pc_i[XLEN-1:2],2'b00}; no request issued this cycle; grant ignored.
//   Pop in same cycle as redirect completes normally (decode owns that instr).
//  Simultaneous push and pop on full or empty queue: both performed, count unchanged.
//  Reset asserted mid-operation: immediate return to reset values; late memory responses
//   after reset are the memory's responsibility (memory shares rst_i).
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetched_o[31:0] (instrs popped to decode) and
//   perf_stall_o[31:0] (cycles in RUN with imem_req_o=0 due to no credit); both reset to 0,
//   saturate at 32'hFFFFFFFF. Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  fetch_pkg: fetch_state_e {IDLE,RUN}; fetch_entry_t {pc, instr}; localparam PC_STEP=4.
//  Sub-module fetch_queue: QDEPTH-entry FIFO of fetch_entry_t with push/pop/flush, count,
//   full/empty; wrap-around read/write pointers.
//  Top: FSM, PC/rsp-PC registers, outstanding and discard counters, credit logic, perf counters.
// TESTING
//  1 reset, start_i=1, 1-cycle memory, ready=1 -> pc_o sequence 0,4,8,12 one per cycle after fill.
//  2 ready=0, QDEPTH=4 -> exactly 4 grants then imem_req_o=0; ready=1 -> drains 0,4,8,12 in order.
//  3 3-cycle memory, redirect_i with pc=0x103 while 2 outstanding -> both responses dropped,
//    next request addr 0x100, next pc_o 0x100.
//  4 redirect_i same cycle as rvalid and pop -> popped instr delivered, rvalid word dropped,
//    queue empty next cycle.
//  5 RESET_PC=0xFFFFFFF8 -> pc_o 0xFFFFFFF8, 0xFFFFFFFC, 0x0; rst_i mid-burst -> outputs at reset values.
//  6 FETCH_PERF_EN: 10 pops with 3 credit-stalled cycles -> perf_fetched_o=10, perf_stall_o=3.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;
    localparam int PC_STEP    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of fetch entries with flush; DEPTH must be a power of two so
// the read/write pointers wrap naturally.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          empty
);

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this cycle, so a push into a full queue is legal then.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC ownership, credit-limited memory requests, response
// queueing and redirect flush. Defining FETCH_PERF_EN adds fetched/stall perf counters.
//
// state | meaning
// IDLE  | no requests issued; responses still accepted, queue still drains to decode
// RUN   | requests issued whenever queue + in-flight leaves a free slot
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = FETCH_XLEN,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched_o,
    output logic [31:0]     perf_stall_o
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

    fetch_state_e    state, state_nx;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   q_count;
    logic [CW:0]     in_flight;
    logic            q_empty;
    logic            credit_ok;
    logic            grant;
    logic            push;
    logic            pop;
    entry_t          q_head;
    entry_t          push_entry;

    assign in_flight   = {1'b0, q_count} + {1'b0, outstanding};
    assign credit_ok   = in_flight < (CW + 1)'(QDEPTH);
    assign redirect_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign grant       = imem_req_o & imem_gnt_i;
    assign push        = imem_rvalid_i & ~redirect_i & (discard == '0);
    assign pop         = instr_valid_o & instr_ready_i;
    assign push_entry  = '{pc: rsp_pc, instr: imem_rdata_i};

    assign imem_addr_o   = fetch_pc;
    assign instr_valid_o = ~q_empty;
    assign instr_o       = q_empty ? '0 : q_head.instr;
    assign pc_o          = q_empty ? '0 : q_head.pc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        imem_req_o = 1'b0;
        case (state)
            IDLE: if (start_i) state_nx = RUN;
            RUN: begin
                if (!start_i) state_nx = IDLE;
                imem_req_o = credit_ok & ~redirect_i;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_i) begin
            // Everything still in flight belongs to the old path; a response landing
            // now is already dropped, so it is not counted again.
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= outstanding - CW'(imem_rvalid_i);
            discard     <= outstanding - CW'(imem_rvalid_i);
        end else begin
            if (grant) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
            if (push)  rsp_pc   <= rsp_pc + XLEN'(PC_STEP);
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid_i);
            if (imem_rvalid_i && discard != '0) discard <= discard - CW'(1);
        end
    end

    fetch_queue #(
        .DEPTH  (QDEPTH),
        .entry_t(entry_t)
    ) u_queue (
        .clk  (clk_i),
        .rst  (rst_i),
        .push (push),
        .wdata(push_entry),
        .pop  (pop),
        .flush(redirect_i),
        .head (q_head),
        .count(q_count),
        .empty(q_empty)
    );

`ifdef FETCH_PERF_EN
    logic stall_cycle;
    assign stall_cycle = (state == RUN) & ~credit_ok & ~redirect_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_fetched_o <= '0;
            perf_stall_o   <= '0;
        end else begin
            if (pop && perf_fetched_o != '1)       perf_fetched_o <= perf_fetched_o + 32'd1;
            if (stall_cycle && perf_stall_o != '1) perf_stall_o   <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus randomized
// memory latency, grant, ready, start and redirect stimulus.
module tb_fetch_unit;

    localparam int QD = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i, instr_o, pc_o, redirect_pc_i;
    logic        instr_valid_o, instr_ready_i, redirect_i;

    logic        start_w, req_w, rvalid_w, valid_w;
    logic [31:0] addr_w, rdata_w, instr_w, pc_w;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched_w, perf_stall_w;
`endif

    always #5 clk_i = ~clk_i;

    fetch_unit #(.XLEN(32), .QDEPTH(QD), .RESET_PC(32'h0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_o(pc_o),
        .instr_ready_i(instr_ready_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
`ifdef FETCH_PERF_EN
        , .perf_fetched_o(perf_fetched), .perf_stall_o(perf_stall)
`endif
    );

    fetch_unit #(.XLEN(32), .QDEPTH(QD), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_w),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_gnt_i(1'b1),
        .imem_rvalid_i(rvalid_w), .imem_rdata_i(rdata_w),
        .instr_valid_o(valid_w), .instr_o(instr_w), .pc_o(pc_w),
        .instr_ready_i(1'b1), .redirect_i(1'b0), .redirect_pc_i(32'h0)
`ifdef FETCH_PERF_EN
        , .perf_fetched_o(perf_fetched_w), .perf_stall_o(perf_stall_w)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          tests = 0, fails = 0, cyc = 0;
    logic [63:0] mq[$];
    logic [31:0] m_fpc, m_rpc;
    int          m_out, m_disc;
    bit          m_run;
    longint      m_fetched, m_stall;
    pend_t       pend[$];

    int          gnt_pct = 100, rdy_pct = 100, rv_pct = 100, redir_pct = 0, flip_pct = 0;
    int          lat_min = 1, lat_max = 1;
    bit          start_v = 0, force_redir = 0;
    logic [31:0] force_pc = 0;

    logic [31:0] pop_log[$], gnt_log[$], w_log[$];
    int          pop_cyc[$];
    bit          w_rv;
    logic [31:0] w_rd;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 0; imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
        instr_ready_i = 0; redirect_i = 0; redirect_pc_i = 0;
        start_w = 0; rvalid_w = 0; rdata_w = 0;
        start_v = 0; force_redir = 0;
        #1;
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", instr_valid_o, 0);
        chk("rst_instr", instr_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_addr_w", addr_w, 32'hFFFF_FFF8);
        chk("rst_valid_w", valid_w, 0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched, 0);
        chk("rst_perf_stall", perf_stall, 0);
`endif
        mq.delete(); pend.delete();
        m_fpc = 0; m_rpc = 0; m_out = 0; m_disc = 0; m_run = 0;
        m_fetched = 0; m_stall = 0; w_rv = 0; w_rd = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic step();
        bit          rv, rdy, gn, rd, exp_req, credit, gr;
        logic [31:0] rdat, rpc;
        if (flip_pct > 0 && $urandom_range(99) < flip_pct) start_v = !start_v;
        rv   = pend.size() > 0 && pend[0].due <= cyc && $urandom_range(99) < rv_pct;
        rdat = rv ? mem_word(pend[0].addr) : $urandom;
        gn   = $urandom_range(99) < gnt_pct;
        rdy  = $urandom_range(99) < rdy_pct;
        rd   = force_redir || ($urandom_range(99) < redir_pct);
        rpc  = force_redir ? force_pc : 32'($urandom_range(0, 4095));
        start_i = start_v; imem_gnt_i = gn; imem_rvalid_i = rv; imem_rdata_i = rdat;
        instr_ready_i = rdy; redirect_i = rd; redirect_pc_i = rpc;
        rvalid_w = w_rv; rdata_w = w_rd;
        #2;
        credit  = (mq.size() + m_out) < QD;
        exp_req = m_run && !rd && credit;
        chk("req", imem_req_o, exp_req);
        chk("addr", imem_addr_o, m_fpc);
        chk("valid", instr_valid_o, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("pc", pc_o, mq[0][63:32]);
            chk("instr", instr_o, mq[0][31:0]);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'(m_fetched));
        chk("perf_stall", perf_stall, 32'(m_stall));
`endif
        if (valid_w) chk("w_instr", instr_w, pc_w);
        if (instr_valid_o && rdy) begin
            pop_log.push_back(pc_o);
            pop_cyc.push_back(cyc);
        end
        if (m_run && !rd && !credit) m_stall++;
        if (mq.size() > 0 && rdy) begin
            void'(mq.pop_front());
            m_fetched++;
        end
        if (rd) begin
            mq.delete();
            m_out  = m_out - int'(rv);
            m_disc = m_out;
            m_fpc  = rpc & ~32'd3;
            m_rpc  = rpc & ~32'd3;
        end else begin
            gr = exp_req && gn;
            if (rv) begin
                if (m_disc > 0) m_disc--;
                else begin
                    mq.push_back({m_rpc, rdat});
                    m_rpc += 32'd4;
                end
            end
            m_out = m_out + int'(gr) - int'(rv);
            if (gr) m_fpc += 32'd4;
        end
        m_run = start_v;
        if (rv) void'(pend.pop_front());
        if (imem_req_o && gn) begin
            pend.push_back('{addr: imem_addr_o, due: cyc + $urandom_range(lat_max, lat_min)});
            gnt_log.push_back(imem_addr_o);
        end
        if (valid_w) w_log.push_back(pc_w);
        w_rv = req_w;
        w_rd = addr_w;
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] exp_t4;
        bit          hit;
        do_reset();

        // 1: single-cycle memory streams one instruction per cycle
        start_v = 1; pop_log.delete(); pop_cyc.delete();
        repeat (12) step();
        if (pop_log.size() >= 4) begin
            chk("t1_pc0", pop_log[0], 32'h0);
            chk("t1_pc1", pop_log[1], 32'h4);
            chk("t1_pc2", pop_log[2], 32'h8);
            chk("t1_pc3", pop_log[3], 32'hC);
            chk("t1_back_to_back", pop_cyc[3] - pop_cyc[0], 3);
        end else chk("t1_pop_count", pop_log.size(), 4);

        // 2: credit limit with decode stalled
        do_reset();
        rdy_pct = 0; start_v = 1; gnt_log.delete();
        repeat (10) step();
        chk("t2_grants", gnt_log.size(), 4);
        chk("t2_req_off", imem_req_o, 0);
`ifdef FETCH_PERF_EN
        chk("t2_stalls", perf_stall, 5);
`endif
        rdy_pct = 100; pop_log.delete();
        repeat (6) step();
        if (pop_log.size() >= 4) begin
            chk("t2_pc0", pop_log[0], 32'h0);
            chk("t2_pc1", pop_log[1], 32'h4);
            chk("t2_pc2", pop_log[2], 32'h8);
            chk("t2_pc3", pop_log[3], 32'hC);
        end else chk("t2_pop_count", pop_log.size(), 4);

        // 3: redirect with two requests in flight on a 3-cycle memory
        do_reset();
        lat_min = 3; lat_max = 3; rdy_pct = 0; start_v = 1; hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = (m_out == 2);
        end
        chk("t3_setup", hit, 1);
        force_redir = 1; force_pc = 32'h103;
        step();
        force_redir = 0; gnt_log.delete(); pop_log.delete(); rdy_pct = 100;
        repeat (12) step();
        chk("t3_addr", gnt_log.size() > 0 ? gnt_log[0] : 32'hDEAD, 32'h100);
        chk("t3_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD, 32'h100);

        // 4: redirect coinciding with a response and a pop
        do_reset();
        lat_min = 1; lat_max = 1; start_v = 1; hit = 0;
        repeat (6) step();
        for (int i = 0; i < 20 && !hit; i++) begin
            hit = mq.size() > 0 && pend.size() > 0 && pend[0].due <= cyc;
            if (!hit) step();
        end
        chk("t4_setup", hit, 1);
        exp_t4 = mq.size() > 0 ? mq[0][63:32] : 32'hDEAD;
        force_redir = 1; force_pc = 32'h200; pop_log.delete();
        step();
        force_redir = 0;
        chk("t4_pop_count", pop_log.size(), 1);
        chk("t4_pop_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD, exp_t4);
        chk("t4_empty", instr_valid_o, 0);
        pop_log.delete();
        repeat (6) step();
        chk("t4_next_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD, 32'h200);

        // 5: PC wrap from a high reset PC, then reset mid-burst
        do_reset();
        start_w = 1; w_log.delete();
        repeat (8) step();
        if (w_log.size() >= 3) begin
            chk("t5_pc0", w_log[0], 32'hFFFF_FFF8);
            chk("t5_pc1", w_log[1], 32'hFFFF_FFFC);
            chk("t5_pc2", w_log[2], 32'h0);
        end else chk("t5_pop_count", w_log.size(), 3);
        start_v = 1; gnt_pct = 100; lat_min = 2; lat_max = 3;
        repeat (5) step();
        do_reset();

        // randomized segments
        for (int s = 0; s < 6; s++) begin
            lat_min   = $urandom_range(3, 1);
            lat_max   = lat_min + $urandom_range(3, 0);
            gnt_pct   = $urandom_range(100, 30);
            rdy_pct   = $urandom_range(100, 20);
            rv_pct    = $urandom_range(100, 50);
            redir_pct = $urandom_range(5, 0);
            flip_pct  = $urandom_range(3, 0);
            start_v   = 1;
            repeat (400) step();
            if (s == 3) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
